// File: rtl/sub_4bit_serial_pkg.sv
// Shared definitions for the bit-serial adder-inverse: FSM state encoding
// and the default operand width.
package sub_4bit_serial_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sub_4bit_serial_fs.sv
// One-bit full subtractor: computes x - y - bi.
// It mirrors the full-adder cell of the ripple adder.
module full_subtractor (
  output logic o_d,
  output logic o_bo,
  input  logic i_x,
  input  logic i_y,
  input  logic i_bi
);

  assign o_d  = i_x ^ i_y ^ i_bi;
  assign o_bo = (~i_x & i_y) | (~(i_x ^ i_y) & i_bi);

endmodule

// File: rtl/sub_4bit_serial.sv
// Bit-serial inverse of the ripple adder. It recovers b = {co,s} - a - ci,
// processing one bit per cycle LSB-first, and flags sums no valid addition could give.
//
// state   | meaning
// S_IDLE  | waiting for an operand set (o_ready=1)
// S_SHIFT | one subtractor bit per cycle, WIDTH cycles
// S_DONE  | result held on o_b/o_err until i_ready
module sub_4bit_serial
  import sub_4bit_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_s,
  input  logic             i_co,
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_ci,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_b,
  output logic             o_err
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic            r_co;
  logic            r_borrow;
  logic            r_err;
  logic [CW-1:0]   r_cnt;
  logic            w_accept;
  logic            w_last;
  logic            w_d;
  logic            w_bo;

  assign w_accept = i_valid & o_ready;
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST);
  assign o_b      = r_b;
  assign o_err    = r_err;

  // Operand registers shift right, so the current bit k is always at index 0.
  full_subtractor u_fs (
    .o_d  (w_d),
    .o_bo (w_bo),
    .i_x  (r_s[0]),
    .i_y  (r_a[0]),
    .i_bi (r_borrow)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_cnt == LAST) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_co     <= 1'b0;
      r_borrow <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_s      <= i_s;
      r_a      <= i_a;
      r_co     <= i_co;
      r_borrow <= i_ci;
      r_cnt    <= '0;
    end else if (r_state == S_SHIFT) begin
      r_s      <= r_s >> 1;
      r_a      <= r_a >> 1;
      r_borrow <= w_bo;
      r_b      <= (r_b >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
      r_cnt    <= r_cnt + CW'(1);
      // Carry-out must exactly cancel the final borrow for a legal addition.
      if (w_last) r_err <= r_co ^ w_bo;
    end
  end

endmodule

// File: tb/tb_sub_4bit_serial.sv
// Scoreboard bench for sub_4bit_serial: the driver queues arithmetic expectations,
// and a negedge monitor checks each result handshake.
module tb_sub_4bit_serial;
  import sub_4bit_serial_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  typedef struct {
    logic [W-1:0] b;
    logic         err;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b1;
  logic [W-1:0] i_s = '0;
  logic [W-1:0] i_a = '0;
  logic         i_co = 1'b0;
  logic         i_ci = 1'b0;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] o_b;
  logic         o_err;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q[$];

  sub_4bit_serial #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_s     (i_s),
    .i_co    (i_co),
    .i_a     (i_a),
    .i_ci    (i_ci),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_b     (o_b),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the (W+1)-bit adder result.
  function automatic exp_t model(logic [W-1:0] s, logic co, logic [W-1:0] a, logic ci, int acc);
    exp_t m;
    int   diff;
    diff  = (int'(co) << W) + int'(s) - int'(a) - int'(ci);
    m.b   = W'(diff & ((1 << W) - 1));
    m.err = (diff < 0) || (diff >= (1 << W));
    m.acc = acc;
    return m;
  endfunction

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic issue(logic [W-1:0] s, logic co, logic [W-1:0] a, logic ci,
                       logic [W-1:0] eb, logic eerr, output int acc);
    int   n;
    exp_t e;
    n = 0;
    acc = -1;
    i_s = s; i_co = co; i_a = a; i_ci = ci; i_valid = 1'b1;
    @(negedge clk);
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      chk("accept_timeout", o_ready, 1);
      i_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc   = cyc;
    e.b   = eb;
    e.err = eerr;
    e.acc = acc;
    q.push_back(e);
    i_valid = 1'b0;
  endtask

  task automatic send(logic [W-1:0] s, logic co, logic [W-1:0] a, logic ci, output int acc);
    exp_t m;
    m = model(s, co, a, ci, 0);
    issue(s, co, a, ci, m.b, m.err, acc);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency on rising o_valid, data on handshake, single-cycle DONE after it.
  logic prev_v = 1'b0;
  logic prev_hs = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) begin
        chk("valid_one_cycle", o_valid, 0);
        chk("ready_after_done", o_ready, 1);
      end
      if (o_valid && !prev_v) begin
        if (q.size() == 0) chk("spurious_valid", o_valid, 0);
        else               chk("latency", cyc - q[0].acc, W);
      end
      prev_hs = 1'b0;
      if (o_valid && i_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("o_b", o_b, e.b);
        chk("o_err", o_err, e.err);
        prev_hs = 1'b1;
      end
      prev_v = o_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int           acc;
    int           prev_acc;
    exp_t         eh;
    logic [8:0]   v;
    logic [W:0]   sum;
    int           n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_b", o_b, 0);
    chk("rst_err", o_err, 0);
    @(posedge clk);
    #1;

    // Directed vectors
    i_ready = 1'b1;
    send(4'd9, 1'b0, 4'd3, 1'b1, acc);
    @(negedge clk);
    chk("ready_in_shift", o_ready, 0);
    chk("valid_in_shift", o_valid, 0);
    @(posedge clk);
    #1;
    wait_drain();
    send(4'd15, 1'b1, 4'd15, 1'b1, acc);
    wait_drain();
    send(4'd2, 1'b0, 4'd5, 1'b0, acc);
    wait_drain();
    send(4'd0, 1'b1, 4'd0, 1'b0, acc);
    wait_drain();

    // Backpressure: hold DONE while the input side is noisy
    i_ready = 1'b0;
    eh = model(4'd6, 1'b1, 4'd7, 1'b0, 0);
    send(4'd6, 1'b1, 4'd7, 1'b0, acc);
    n = 0;
    while (!o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reach_done", o_valid, 1);
    repeat (10) begin
      @(posedge clk);
      #1;
      i_valid = 1'($urandom);
      i_s     = W'($urandom);
      i_a     = W'($urandom);
      i_co    = 1'($urandom);
      i_ci    = 1'($urandom);
      @(negedge clk);
      chk("hold_valid", o_valid, 1);
      chk("hold_b", o_b, eh.b);
      chk("hold_err", o_err, eh.err);
      chk("hold_ready", o_ready, 0);
    end
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    i_valid = 1'b1; i_s = 4'd12; i_co = 1'b0; i_a = 4'd4; i_ci = 1'b1;
    @(negedge clk);
    chk("release_ready", o_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_after_release", o_ready, 1);
    q.push_back(model(4'd12, 1'b0, 4'd4, 1'b1, cyc + 1));
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("accepted_after_idle", o_ready, 0);
    @(posedge clk);
    #1;
    wait_drain();

    // Reset during the second SHIFT cycle aborts the set
    send(4'd11, 1'b0, 4'd2, 1'b0, acc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", o_ready, 1);
    chk("abort_valid", o_valid, 0);
    chk("abort_b", o_b, 0);
    chk("abort_err", o_err, 0);
    repeat (8) begin
      @(negedge clk);
      chk("no_valid_after_abort", o_valid, 0);
    end
    @(posedge clk);
    #1;
    send(4'd11, 1'b0, 4'd2, 1'b0, acc);
    wait_drain();

    // Random back-to-back sets; accepts must be WIDTH+2 apart
    prev_acc = -1;
    for (int i = 0; i < 20; i++) begin
      send(W'($urandom), 1'($urandom), W'($urandom), 1'($urandom), acc);
      if (prev_acc >= 0) chk("throughput", acc - prev_acc, W + 2);
      prev_acc = acc;
    end
    wait_drain();

    // Round trip through a behavioural adder: the original b must come back
    for (int i = 0; i < 10; i++) begin
      v   = 9'($urandom_range(0, 2**9 - 1));
      sum = (W+1)'(v[3:0]) + (W+1)'(v[7:4]) + (W+1)'(v[8]);
      issue(sum[W-1:0], sum[W], v[3:0], v[8], v[7:4], 1'b0, acc);
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
